// File: rtl/owm_rx_filter.sv
// owm_rx_filter: per-channel 1-wire pad synchroniser, glitch filter, edge pulses and stuck-low flag.
// Stuck-low detector is built only when OWM_RX_STUCK_EN is defined.
module owm_rx_filter #(
  parameter int CH    = 2,
  parameter int FN    = 3,
  parameter int STUCK = 24000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] pad_i,
  output logic [CH-1:0] wire_o,
  output logic [CH-1:0] fall_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] stuck_o,
  input  logic          stuck_clr
);
  localparam int CW = (FN > 1) ? $clog2(FN) : 1;
  localparam int LW = $clog2(STUCK);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          s1_q, s2_q, wire_q, wire_d, fall_q, rise_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chg;
    always_comb begin
      chg    = (s2_q != wire_q) && (cnt_q == CW'(FN - 1));
      cnt_d  = (s2_q != wire_q && !chg) ? cnt_q + 1'b1 : '0;
      wire_d = chg ? s2_q : wire_q;
    end
    // Edge pulses are registered with wire_q so they line up with the new level.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_q   <= 1'b1;
        s2_q   <= 1'b1;
        wire_q <= 1'b1;
        cnt_q  <= '0;
        fall_q <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        s1_q   <= pad_i[i];
        s2_q   <= s1_q;
        wire_q <= wire_d;
        cnt_q  <= cnt_d;
        fall_q <= chg && !s2_q;
        rise_q <= chg && s2_q;
      end
    end
    assign wire_o[i] = wire_q;
    assign fall_o[i] = fall_q;
    assign rise_o[i] = rise_q;
`ifdef OWM_RX_STUCK_EN
    logic [LW-1:0] lc_q;
    logic          st_q;
    // Clearing on the next level lets a rise drop the flag in the same cycle wire_o goes high.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lc_q <= '0;
        st_q <= 1'b0;
      end else if (stuck_clr || wire_d) begin
        lc_q <= '0;
        st_q <= 1'b0;
      end else if (!wire_q && !st_q) begin
        lc_q <= lc_q + 1'b1;
        st_q <= (lc_q == LW'(STUCK - 1));
      end
    end
    assign stuck_o[i] = st_q;
`else
    assign stuck_o[i] = 1'b0;
`endif
  end
`ifndef OWM_RX_STUCK_EN
  logic unused_clr;
  assign unused_clr = stuck_clr;
`endif
endmodule
